vector_hazard_scoreboard: RTL

//  Parametrised hazard unit for the 5-stage vector CPU (F/D/E/M/W).
//  - Forwarding: M and W results to the E-stage operands.
//  - Load-use stall.
//  - Branch flush.
//  - Per-register scoreboard for multi-cycle vector ops that write back outside the M/W path.

---
 rtl/vector_hazard_scoreboard_if.sv | 47 ++++
 rtl/vector_hazard_scoreboard.sv | 105 ++++++++++
 2 files changed

// File: rtl/vector_hazard_scoreboard_if.sv
// Pipeline-side bundle for the vector hazard unit: register addresses and write
// enables in, operand-forward selects, stall/flush enables and scoreboard status out.
interface vector_hazard_scoreboard_if #(
  parameter int AW     = 4,
  parameter int CW     = 3,
  parameter int SCNT_W = 16
);
  logic [AW-1:0]      RA1D;
  logic [AW-1:0]      RA2D;
  logic [AW-1:0]      WA3D;
  logic               RegWriteD;
  logic [AW-1:0]      RA1E;
  logic [AW-1:0]      RA2E;
  logic [AW-1:0]      WA3E;
  logic               RegWriteE;
  logic               MemtoRegE;
  logic [CW-1:0]      LatE;
  logic [AW-1:0]      WA3M;
  logic               RegWriteM;
  logic [AW-1:0]      WA3W;
  logic               RegWriteW;
  logic               BranchTakenE;
  logic [1:0]         ForwardAE;
  logic [1:0]         ForwardBE;
  logic               StallF;
  logic               StallD;
  logic               FlushD;
  logic               FlushE;
  logic [(1<<AW)-1:0] BusyMask;
  logic [SCNT_W-1:0]  StallCount;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD,
    output RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, LatE,
    output WA3M, RegWriteM, WA3W, RegWriteW, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    input  BusyMask, StallCount
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD,
    input  RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, LatE,
    input  WA3M, RegWriteM, WA3W, RegWriteW, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    output BusyMask, StallCount
  );
endinterface

// File: rtl/vector_hazard_scoreboard.sv
// Hazard unit for the 5-stage vector pipeline: M/W forwarding, load-use stall,
// branch flush and a per-register latency scoreboard for multi-cycle ops.
module vector_hazard_scoreboard #(
  parameter int AW     = 4,
  parameter int CW     = 3,
  parameter int SCNT_W = 16
) (
  input logic                      clk,
  input logic                      rst,
  vector_hazard_scoreboard_if.slave hif
);
  localparam int NREGS = 1 << AW;

  logic [NREGS-1:0][CW-1:0] pend_q, pend_d;
  logic [SCNT_W-1:0]        stall_count_q, stall_count_d;
  logic [NREGS-1:0]         busy;

  logic [1:0] fwd_a, fwd_b;
  logic       ldr, sb, mc, hz_any, issue_mc;
  logic       stall_f, stall_d, flush_d, flush_e;

  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] ra,
    input logic [AW-1:0] wa_m,
    input logic          we_m,
    input logic [AW-1:0] wa_w,
    input logic          we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (ra == wa_m))      sel = 2'b10;
    else if (we_w && (ra == wa_w)) sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    busy = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy[i] = (pend_q[i] != '0);
    end
  end

  always_comb begin
    fwd_a = fwd_sel(hif.RA1E, hif.WA3M, hif.RegWriteM, hif.WA3W, hif.RegWriteW);
    fwd_b = fwd_sel(hif.RA2E, hif.WA3M, hif.RegWriteM, hif.WA3W, hif.RegWriteW);
  end

  // mc covers the issue cycle, when pend has not yet been loaded for WA3E
  always_comb begin
    issue_mc = hif.RegWriteE && (hif.LatE != '0);
    ldr      = hif.MemtoRegE && ((hif.RA1D == hif.WA3E) || (hif.RA2D == hif.WA3E));
    sb       = busy[hif.RA1D] || busy[hif.RA2D] || (hif.RegWriteD && busy[hif.WA3D]);
    mc       = issue_mc && ((hif.RA1D == hif.WA3E) || (hif.RA2D == hif.WA3E) ||
                            (hif.RegWriteD && (hif.WA3D == hif.WA3E)));
    hz_any   = ldr || sb || mc;
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (rst || hif.BranchTakenE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      stall_f = hz_any;
      stall_d = hz_any;
      flush_e = hz_any;
    end
  end

  // A fresh issue overrides any count still running on the same register
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NREGS; i++) begin
      if (pend_q[i] != '0) pend_d[i] = pend_q[i] - CW'(1);
    end
    if (issue_mc) pend_d[hif.WA3E] = hif.LatE;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_d && (stall_count_q != '1)) stall_count_d = stall_count_q + SCNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q        <= '0;
      stall_count_q <= '0;
    end else begin
      pend_q        <= pend_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign hif.ForwardAE  = rst ? 2'b00 : fwd_a;
  assign hif.ForwardBE  = rst ? 2'b00 : fwd_b;
  assign hif.StallF     = stall_f;
  assign hif.StallD     = stall_d;
  assign hif.FlushD     = flush_d;
  assign hif.FlushE     = flush_e;
  assign hif.BusyMask   = busy;
  assign hif.StallCount = stall_count_q;
endmodule
